// File: rtl/audioqsys_pio_pkg.sv
// Shared constants for the PIO input block: register map and edge-type encodings.
package audioqsys_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_DIR     = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Anything other than falling/any is treated as rising.
    function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
        logic hit;
        hit = 1'b0;
        if (edge_type == EDGE_ANY) begin
            hit = cur ^ prev;
        end else if (edge_type == EDGE_FALLING) begin
            hit = ~cur & prev;
        end else begin
            hit = cur & ~prev;
        end
        return hit;
    endfunction

endpackage

// File: rtl/audioqsys_pio_debounce.sv
// One input bit: synchroniser chain, optional debounce counter, stable value and edge pulse.
module audioqsys_pio_debounce
    import audioqsys_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   synced;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = stable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = synced;
        end else begin : g_debounce
            localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_q;
            logic             stable_d;

            // The count tracks consecutive cycles of disagreement; any agreement restarts it.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (synced != stable_q) begin
                    if (cnt_q == CNT_TOP) begin
                        stable_d = synced;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable = stable_q;
        end
    endgenerate

    assign edge_pulse = edge_hit(EDGE_TYPE, stable, prev_q);

endmodule

// File: rtl/audioqsys_pio_in_irq.sv
// Avalon-MM PIO input port with per-bit synchronise/debounce, edge capture and masked level IRQ.
module audioqsys_pio_in_irq
    import audioqsys_pio_pkg::*;
#(
    parameter int WIDTH           = 18,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r            = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            audioqsys_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .EDGE_TYPE       (EDGE_TYPE)
            ) u_bit (
                .clk        (clk),
                .reset      (reset),
                .din        (in_port[i]),
                .stable     (stable[i]),
                .edge_pulse (edge_pulse[i])
            );
        end
    endgenerate

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        edgecap_d  = edgecap_q;
        irqmask_d  = irqmask_q;
        readdata_d = '0;

        if (wr_en && (address == ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // New edges are OR-ed in after the clear so a coincident edge survives.
        edgecap_d = edgecap_d | edge_pulse;

        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end

        case (address)
            ADDR_DATA:    readdata_d = zext(stable);
            ADDR_DIR:     readdata_d = '0;
            ADDR_IRQMASK: readdata_d = zext(irqmask_q);
            ADDR_EDGECAP: readdata_d = zext(edgecap_q);
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
        end else begin
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_audioqsys_pio_in_irq.sv
// Bench for audioqsys_pio_in_irq: two parameterisations against a history-window reference model.
module tb_audioqsys_pio_in_irq;

    localparam int W = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd0, rd1;
    logic          irq0, irq1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audioqsys_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

    audioqsys_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));

    function automatic int sp(input int k); return (k == 0) ? 2 : 3; endfunction
    function automatic int np(input int k); return (k == 0) ? 0 : 4; endfunction
    function automatic int ep(input int k); return (k == 0) ? 0 : 2; endfunction

    // Reference model: m_sync[k][0] is the newest sample of in_port; m_win keeps recent synced samples.
    logic [W-1:0] m_sync   [2][4];
    logic [W-1:0] m_win    [2][8];
    int           m_wv     [2];
    logic [W-1:0] m_stable [2];
    logic [W-1:0] m_prev   [2];
    logic [W-1:0] m_ecap   [2];
    logic [W-1:0] m_mask   [2];
    logic [31:0]  m_rd     [2];

    always @(posedge clk) begin : model
        logic [W-1:0] st, syn, edg, nst, clr;
        logic         wr, all_diff;
        wr = chipselect && !write_n;
        for (int k = 0; k < 2; k++) begin
            syn = m_sync[k][sp(k)-1];
            st  = (np(k) == 0) ? syn : m_stable[k];
            edg = '0;
            for (int b = 0; b < W; b++) begin
                if (st[b] != m_prev[k][b]) begin
                    if (ep(k) == 2 || (ep(k) == 0 && st[b]) || (ep(k) == 1 && !st[b])) edg[b] = 1'b1;
                end
            end
            if (reset) begin
                for (int i = 0; i < 4; i++) m_sync[k][i] = '0;
                for (int i = 0; i < 8; i++) m_win[k][i] = '0;
                m_wv[k] = 0;
                m_stable[k] = '0;
                m_prev[k] = '0;
                m_ecap[k] = '0;
                m_mask[k] = '0;
                m_rd[k] = '0;
            end else begin
                case (address)
                    2'd0:    m_rd[k] = 32'(st);
                    2'd2:    m_rd[k] = 32'(m_mask[k]);
                    2'd3:    m_rd[k] = 32'(m_ecap[k]);
                    default: m_rd[k] = 32'd0;
                endcase
                for (int i = 7; i > 0; i--) m_win[k][i] = m_win[k][i-1];
                m_win[k][0] = syn;
                if (m_wv[k] < 8) m_wv[k]++;
                // A bit flips once its last N synced samples all disagree with it.
                nst = m_stable[k];
                if (np(k) > 0 && m_wv[k] >= np(k)) begin
                    for (int b = 0; b < W; b++) begin
                        all_diff = 1'b1;
                        for (int i = 0; i < np(k); i++)
                            if (m_win[k][i][b] == m_stable[k][b]) all_diff = 1'b0;
                        if (all_diff) nst[b] = ~nst[b];
                    end
                end
                m_stable[k] = nst;
                for (int i = 3; i > 0; i--) m_sync[k][i] = m_sync[k][i-1];
                m_sync[k][0] = in_port;
                m_prev[k] = st;
                clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
                m_ecap[k] = (m_ecap[k] & ~clr) | edg;
                if (wr && address == 2'd2) m_mask[k] = writedata[W-1:0];
            end
        end
    end

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        chk32({tag, "/rd0"}, rd0, m_rd[0]);
        chk32({tag, "/rd1"}, rd1, m_rd[1]);
        chk32({tag, "/irq0"}, {31'd0, irq0}, {31'd0, |(m_ecap[0] & m_mask[0])});
        chk32({tag, "/irq1"}, {31'd0, irq1}, {31'd0, |(m_ecap[1] & m_mask[1])});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick("wr");
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick("reset");
        chk32("reset_rd0", rd0, 32'd0);
        chk32("reset_irq1", {31'd0, irq1}, 32'd0);

        // Read latency from in_port to address 0.
        reset = 1'b0;
        address = 2'd0;
        in_port = 18'h2A5A5;
        tick("lat");
        tick("lat");
        chk32("lat_u0_early", rd0, 32'd0);
        tick("lat");
        chk32("lat_u0", rd0, 32'h0002A5A5);
        repeat (4) tick("lat");
        chk32("lat_u1_early", rd1, 32'd0);
        tick("lat");
        chk32("lat_u1", rd1, 32'h0002A5A5);

        // Debounce: short pulse rejected, long pulse accepted.
        in_port = '0;
        repeat (12) tick("settle");
        bus_write(2'd3, 32'hFFFF_FFFF);
        address = 2'd3;
        tick("clr");
        chk32("clr_rd1", rd1, 32'd0);
        in_port = 18'h1;
        repeat (3) tick("glitch");
        in_port = '0;
        repeat (12) tick("glitch");
        chk32("glitch_ecap_u1", rd1, 32'd0);
        chk32("glitch_ecap_u0", rd0, 32'h1);
        address = 2'd0;
        tick("glitch");
        chk32("glitch_stable_u1", rd1, 32'd0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port = 18'h1;
        repeat (6) tick("pulse");
        in_port = '0;
        address = 2'd3;
        repeat (14) tick("pulse");
        chk32("pulse_ecap_u1", rd1, 32'h1);

        // Masked rising edge raises irq; clearing drops it on the next cycle.
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h1);
        in_port = 18'h1;
        address = 2'd3;
        repeat (10) tick("irq");
        chk32("irq_ecap_u0", rd0, 32'h1);
        chk32("irq_u0", {31'd0, irq0}, 32'd1);
        bus_write(2'd3, 32'h1);
        chk32("irq_clr_u0", {31'd0, irq0}, 32'd0);
        chk32("irq_clr_u1", {31'd0, irq1}, 32'd0);

        // Clear write on bit 2 in the same cycle as a new bit-2 edge on u0.
        in_port = 18'h5;
        tick("setclr");
        tick("setclr");
        bus_write(2'd3, 32'h4);
        tick("setclr");
        chk32("set_wins_u0", rd0 & 32'h4, 32'h4);

        // Any-edge capture on bit 5 with mask off, then mask on.
        bus_write(2'd2, 32'h0);
        repeat (12) tick("any");
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port = in_port ^ 18'h20;
        address = 2'd3;
        repeat (10) tick("any");
        chk32("any_ecap_u1", rd1, 32'h20);
        chk32("any_irq_off_u1", {31'd0, irq1}, 32'd0);
        bus_write(2'd2, 32'h20);
        chk32("any_irq_on_u1", {31'd0, irq1}, 32'd1);

        // Input held high through reset produces one edge after release.
        in_port = 18'h1;
        reset = 1'b1;
        repeat (4) tick("hold");
        reset = 1'b0;
        address = 2'd3;
        tick("hold");
        chk32("hold_zero_u0", rd0, 32'd0);
        chk32("hold_zero_u1", rd1, 32'd0);
        repeat (10) tick("hold");
        chk32("hold_edge_u0", rd0, 32'h1);
        chk32("hold_edge_u1", rd1, 32'h1);

        // Reset in the middle of a debounce count records nothing.
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port = '0;
        repeat (5) tick("abort");
        reset = 1'b1;
        tick("abort");
        reset = 1'b0;
        address = 2'd3;
        repeat (12) tick("abort");
        chk32("abort_u1", rd1, 32'd0);

        // Randomised traffic, including glitches, bus writes and occasional resets.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) in_port = in_port ^ (18'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 31) == 0) in_port = W'($urandom);
            address = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n = ($urandom_range(0, 1) == 0);
            writedata = $urandom;
            reset = ($urandom_range(0, 99) == 0);
            tick("rand");
        end
        reset = 1'b0;
        chipselect = 1'b0;
        write_n = 1'b1;
        tick("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
